// File: rtl/mips_pipeline.sv
// mips_pipeline: five-stage in-order MIPS32-subset pipeline (IF, ID, EX, MEM, WB)
// with its own 64-word instruction ROM, 32x32 register file and 64-word data memory.
// Every pipeline register carries its instruction's control bits alongside the data.
// There is no forwarding, no hazard detection and there are no branches.
// Ports:
//   clk        in   1   rising-edge clock for all state
//   rst        in   1   synchronous, active-high reset
//   pc_out     out  32  current IF-stage PC register
//   alu_result out  32  write-back value held in MEM/WB (load data for lw, ALU result otherwise)
module mips_pipeline (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  output logic [31:0] alu_result
);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    alu_op_e    alu_op;
    logic [4:0] dest;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_ext;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] value;
  } mem_wb_t;

  logic [31:0] pc_q, pc_d;
  if_id_t      if_id_q, if_id_d;
  id_ex_t      id_ex_q, id_ex_d;
  ex_mem_t     ex_mem_q, ex_mem_d;
  mem_wb_t     mem_wb_q, mem_wb_d;

  logic [31:0] regs_q [32];
  logic [31:0] dmem_q [64];

  logic [31:0] instr;
  logic [31:0] alu_b;
  logic        rf_we;
  logic        dmem_we;

  function automatic logic [31:0] rom_word(input logic [5:0] idx);
    case (idx)
      6'd0:    rom_word = 32'h2001_0005; // addi $1,$0,5
      6'd1:    rom_word = 32'h2002_000A; // addi $2,$0,10
      6'd4:    rom_word = 32'h0022_1820; // add  $3,$1,$2
      6'd5:    rom_word = 32'h0041_2022; // sub  $4,$2,$1
      6'd6:    rom_word = 32'h0022_2824; // and  $5,$1,$2
      6'd7:    rom_word = 32'h0022_3025; // or   $6,$1,$2
      6'd8:    rom_word = 32'h0022_382A; // slt  $7,$1,$2
      6'd9:    rom_word = 32'hAC03_0000; // sw   $3,0($0)
      6'd10:   rom_word = 32'h8C08_0000; // lw   $8,0($0)
      default: rom_word = 32'h0000_0000; // nop
    endcase
  endfunction

  // Register read with write-through bypass from the write-back stage.
  function automatic logic [31:0] rf_read(input logic [4:0] idx, input mem_wb_t wb,
                                          input logic [31:0] stored);
    if (idx == 5'd0)                        rf_read = '0;
    else if (wb.reg_write && wb.dest == idx) rf_read = wb.value;
    else                                    rf_read = stored;
  endfunction

  // IF: fetch and decode. Unrecognised words leave every field zero so they
  // flow through as a true NOP producing a zero result.
  always_comb begin
    pc_d    = pc_q + 32'd4;
    instr   = rom_word(pc_q[7:2]);
    if_id_d = '0;
    case (instr[31:26])
      6'h00: begin
        if_id_d.ctrl.reg_write = 1'b1;
        if_id_d.ctrl.dest      = instr[15:11];
        if_id_d.rs             = instr[25:21];
        if_id_d.rt             = instr[20:16];
        case (instr[5:0])
          6'h20:   if_id_d.ctrl.alu_op = ALU_ADD;
          6'h22:   if_id_d.ctrl.alu_op = ALU_SUB;
          6'h24:   if_id_d.ctrl.alu_op = ALU_AND;
          6'h25:   if_id_d.ctrl.alu_op = ALU_OR;
          6'h2A:   if_id_d.ctrl.alu_op = ALU_SLT;
          default: if_id_d = '0;
        endcase
      end
      6'h08: begin
        if_id_d.ctrl.reg_write = 1'b1;
        if_id_d.ctrl.alu_src   = 1'b1;
        if_id_d.ctrl.dest      = instr[20:16];
        if_id_d.rs             = instr[25:21];
        if_id_d.imm            = instr[15:0];
      end
      6'h23: begin
        if_id_d.ctrl.reg_write  = 1'b1;
        if_id_d.ctrl.mem_to_reg = 1'b1;
        if_id_d.ctrl.alu_src    = 1'b1;
        if_id_d.ctrl.dest       = instr[20:16];
        if_id_d.rs              = instr[25:21];
        if_id_d.imm             = instr[15:0];
      end
      6'h2B: begin
        if_id_d.ctrl.mem_write = 1'b1;
        if_id_d.ctrl.alu_src   = 1'b1;
        if_id_d.rs             = instr[25:21];
        if_id_d.rt             = instr[20:16];
        if_id_d.imm            = instr[15:0];
      end
      default: if_id_d = '0;
    endcase
  end

  // ID: operand read.
  always_comb begin
    id_ex_d         = '0;
    id_ex_d.ctrl    = if_id_q.ctrl;
    id_ex_d.rs_val  = rf_read(if_id_q.rs, mem_wb_q, regs_q[if_id_q.rs]);
    id_ex_d.rt_val  = rf_read(if_id_q.rt, mem_wb_q, regs_q[if_id_q.rt]);
    id_ex_d.imm_ext = {{16{if_id_q.imm[15]}}, if_id_q.imm};
  end

  // EX: ALU.
  always_comb begin
    alu_b               = id_ex_q.ctrl.alu_src ? id_ex_q.imm_ext : id_ex_q.rt_val;
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = id_ex_q.ctrl.reg_write;
    ex_mem_d.mem_to_reg = id_ex_q.ctrl.mem_to_reg;
    ex_mem_d.mem_write  = id_ex_q.ctrl.mem_write;
    ex_mem_d.dest       = id_ex_q.ctrl.dest;
    ex_mem_d.store_data = id_ex_q.rt_val;
    case (id_ex_q.ctrl.alu_op)
      ALU_SUB: ex_mem_d.alu = id_ex_q.rs_val - alu_b;
      ALU_AND: ex_mem_d.alu = id_ex_q.rs_val & alu_b;
      ALU_OR:  ex_mem_d.alu = id_ex_q.rs_val | alu_b;
      ALU_SLT: ex_mem_d.alu = {31'd0, $signed(id_ex_q.rs_val) < $signed(alu_b)};
      default: ex_mem_d.alu = id_ex_q.rs_val + alu_b;
    endcase
  end

  // MEM: combinational load so a load right after a store sees the new data.
  always_comb begin
    dmem_we            = ex_mem_q.mem_write;
    mem_wb_d           = '0;
    mem_wb_d.reg_write = ex_mem_q.reg_write;
    mem_wb_d.dest      = ex_mem_q.dest;
    mem_wb_d.value     = ex_mem_q.mem_to_reg ? dmem_q[ex_mem_q.alu[7:2]] : ex_mem_q.alu;
    rf_we              = mem_wb_q.reg_write && (mem_wb_q.dest != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      if_id_q  <= '0;
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      pc_q     <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) regs_q[k] <= '0;
      for (int k = 0; k < 64; k++) dmem_q[k] <= '0;
    end else begin
      if (rf_we)   regs_q[mem_wb_q.dest]      <= mem_wb_q.value;
      if (dmem_we) dmem_q[ex_mem_q.alu[7:2]] <= ex_mem_q.store_data;
    end
  end

  assign pc_out     = pc_q;
  assign alu_result = mem_wb_q.value;

endmodule

// File: tb/tb_mips_pipeline.sv
// Directed bench for mips_pipeline: reset values, first pass through the
// program, mid-run reset and replay, and ROM index wrap after 64 fetches.
module tb_mips_pipeline;

  logic        clk;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] alu_result;

  int checks   = 0;
  int failures = 0;

  mips_pipeline dut (
    .clk        (clk),
    .rst        (rst),
    .pc_out     (pc_out),
    .alu_result (alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected write-back value of program word w (hand-computed from the ROM listing).
  function automatic logic [31:0] word_result(input int w);
    case (w % 64)
      0:       word_result = 32'd5;   // addi $1
      1:       word_result = 32'd10;  // addi $2
      4:       word_result = 32'd15;  // add
      5:       word_result = 32'd5;   // sub
      6:       word_result = 32'd0;   // and
      7:       word_result = 32'd15;  // or
      8:       word_result = 32'd1;   // slt
      9:       word_result = 32'd0;   // sw address
      10:      word_result = 32'd15;  // lw
      default: word_result = 32'd0;
    endcase
  endfunction

  // alu_result expected after edge n following reset release.
  function automatic logic [31:0] exp_result(input int n);
    if (n < 4) exp_result = 32'd0;
    else       exp_result = word_result(n - 4);
  endfunction

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held for two edges.
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      step();
      check($sformatf("reset_pc_e%0d", e), pc_out, 32'd0);
      check($sformatf("reset_res_e%0d", e), alu_result, 32'd0);
    end
    $display("reset phase: pc_out=%0d alu_result=%0d", pc_out, alu_result);

    // First run up to edge 12; covers bypass (add=15 at edge 8), slt and early results.
    rst = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      step();
      check($sformatf("run1_pc_e%0d", n), pc_out, 32'(4 * n));
      check($sformatf("run1_res_e%0d", n), alu_result, exp_result(n));
      $display("run1 edge %0d: pc_out=%0d alu_result=%0d", n, pc_out, alu_result);
    end

    // Mid-run reset for one edge discards in-flight instructions.
    rst = 1'b1;
    step();
    check("midreset_pc", pc_out, 32'd0);
    check("midreset_res", alu_result, 32'd0);
    $display("mid-run reset: pc_out=%0d alu_result=%0d", pc_out, alu_result);

    // Replay for 70 edges: same sequence, store/load, then ROM wrap at edge 68.
    rst = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      step();
      check($sformatf("run2_pc_e%0d", n), pc_out, 32'(4 * n));
      check($sformatf("run2_res_e%0d", n), alu_result, exp_result(n));
      $display("run2 edge %0d: pc_out=%0d alu_result=%0d", n, pc_out, alu_result);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
